// File: rtl/pipe_icache_pkg.sv
// pipe_icache_pkg
// Shared constants for the IF-stage instruction cache: word/address width,
// default index width, and the tag width derived from the address split
// (index = addr[IDX_BITS+1:2], tag = addr[31:IDX_BITS+2]).
package pipe_icache_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned IDX_BITS_DEF = 6;

  // Tag covers everything above the index and the byte offset.
  function automatic int unsigned tag_width(input int unsigned idx_bits);
    return WORD_W - idx_bits - 2;
  endfunction

endpackage

// File: rtl/pipe_icache_line_array.sv
// icache_line_array
// Storage for the direct-mapped cache lines: one valid bit, one tag and one
// data word per line. Asynchronous read port, single synchronous write port.
// Only the valid bits are reset; tag/data are plain storage so they can map
// to distributed RAM.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (clears valid)
//   rd_idx_i            read index
//   rd_valid_o/tag_o/data_o  contents of the addressed line
//   we_i, wr_idx_i, wr_tag_i, wr_data_i  line write (sets valid)
module icache_line_array
  import pipe_icache_pkg::*;
#(
  parameter int unsigned IDX_BITS = IDX_BITS_DEF,
  parameter int unsigned TAG_W    = tag_width(IDX_BITS_DEF)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic                rd_valid_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [WORD_W-1:0]   rd_data_o,
  input  logic                we_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]    wr_tag_i,
  input  logic [WORD_W-1:0]   wr_data_i
);

  localparam int unsigned NLINES = 2 ** IDX_BITS;

  logic [NLINES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q  [NLINES];
  logic [WORD_W-1:0] data_q [NLINES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // The write enable already excludes reset, so no reset term is needed here.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/pipe_icache.sv
// pipe_icache
// Direct-mapped, write-once instruction cache between the IF-stage PC and
// the slow instruction ROM. Hits return the word combinationally; misses
// pass the memory response straight through and fill the line on the first
// edge where memory is ready. No miss state is held: the request always
// follows the current PC.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   p_a_i            fetch address (PC)
//   p_din_o          instruction to IF
//   p_ready_o        p_din_o valid this cycle (IF stalls when low)
//   m_a_o            memory address (always the PC)
//   m_dout_i         memory read data
//   m_strobe_o       memory request, high on a miss
//   m_ready_i        memory data valid this cycle
//   hit_cnt_o        completed hits since reset
//   miss_cnt_o       completed fills since reset
module pipe_icache
  import pipe_icache_pkg::*;
#(
  parameter int unsigned IDX_BITS = IDX_BITS_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] p_a_i,
  output logic [WORD_W-1:0] p_din_o,
  output logic              p_ready_o,
  output logic [WORD_W-1:0] m_a_o,
  input  logic [WORD_W-1:0] m_dout_i,
  output logic              m_strobe_o,
  input  logic              m_ready_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int unsigned TAG_W = tag_width(IDX_BITS);

  logic [IDX_BITS-1:0] idx;
  logic [TAG_W-1:0]    tag;
  logic                line_valid;
  logic [TAG_W-1:0]    line_tag;
  logic [WORD_W-1:0]   line_data;
  logic                hit;
  logic                fill;

  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  assign idx = p_a_i[IDX_BITS+1:2];
  assign tag = p_a_i[WORD_W-1:IDX_BITS+2];

  icache_line_array #(
    .IDX_BITS (IDX_BITS),
    .TAG_W    (TAG_W)
  ) u_lines (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (idx),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .we_i       (fill),
    .wr_idx_i   (idx),
    .wr_tag_i   (tag),
    .wr_data_i  (m_dout_i)
  );

  assign hit  = line_valid && (line_tag == tag);
  // Reset wins over a same-cycle memory response.
  assign fill = !hit && m_ready_i && !rst_i;

  always_comb begin
    m_a_o      = p_a_i;
    m_strobe_o = !hit;
    p_din_o    = m_dout_i;
    p_ready_o  = m_ready_i;
    if (hit) begin
      p_din_o   = line_data;
      p_ready_o = 1'b1;
    end
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (fill) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_pipe_icache.sv
module tb_pipe_icache;

  localparam int unsigned IDX = 6;
  localparam int unsigned NL  = 2 ** IDX;

  logic        clk;
  logic        rst;
  logic [31:0] p_a;
  logic [31:0] p_din;
  logic        p_ready;
  logic [31:0] m_a;
  logic [31:0] m_dout;
  logic        m_strobe;
  logic        m_ready;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: each line remembers which word address it currently
  // holds and that word's value; an absent key means the line is empty.
  logic [31:0] res_addr [int];
  logic [31:0] res_data [int];
  int unsigned mdl_hits  = 0;
  int unsigned mdl_fills = 0;

  pipe_icache #(.IDX_BITS(IDX)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .p_a_i      (p_a),
    .p_din_o    (p_din),
    .p_ready_o  (p_ready),
    .m_a_o      (m_a),
    .m_dout_i   (m_dout),
    .m_strobe_o (m_strobe),
    .m_ready_i  (m_ready),
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 4) % NL);
  endfunction

  function automatic bit mdl_hit(input logic [31:0] a);
    int l;
    l = line_of(a);
    return res_addr.exists(l) && (res_addr[l] == (a & 32'hFFFF_FFFC));
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h2400_0000 ^ (a * 32'h0001_0101);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Compare all outputs against the model for the current inputs.
  task automatic chk_model(input string tag);
    bit h;
    h = mdl_hit(p_a);
    chk({tag, ":m_a"}, m_a, p_a);
    chk({tag, ":m_strobe"}, {31'd0, m_strobe}, {31'd0, !h});
    chk({tag, ":p_ready"}, {31'd0, p_ready}, {31'd0, h ? 1'b1 : m_ready});
    if (h || m_ready)
      chk({tag, ":p_din"}, p_din, h ? res_data[line_of(p_a)] : m_dout);
    chk({tag, ":hit_cnt"}, hit_cnt, mdl_hits);
    chk({tag, ":miss_cnt"}, miss_cnt, mdl_fills);
  endtask

  // Apply the clock edge to the model, then let the DUT take the same edge.
  task automatic advance();
    if (rst) begin
      res_addr.delete();
      res_data.delete();
      mdl_hits  = 0;
      mdl_fills = 0;
    end else if (mdl_hit(p_a)) begin
      mdl_hits++;
    end else if (m_ready) begin
      res_addr[line_of(p_a)] = p_a & 32'hFFFF_FFFC;
      res_data[line_of(p_a)] = m_dout;
      mdl_fills++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int phase;
    bit got;
    logic [31:0] a;

    rst = 1'b1; p_a = '0; m_dout = '0; m_ready = 1'b0;
    advance();
    advance();
    rst = 1'b0;
    #1;
    chk("rst_m_strobe", {31'd0, m_strobe}, 32'd1);
    chk("rst_p_ready", {31'd0, p_ready}, 32'd0);
    chk("rst_m_a", m_a, 32'h0000_0000);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);

    m_ready = 1'b1; m_dout = 32'h3C01_0000;
    #1;
    chk("miss_pass_ready", {31'd0, p_ready}, 32'd1);
    chk("miss_pass_din", p_din, 32'h3C01_0000);
    advance();
    m_ready = 1'b0; m_dout = 32'hFFFF_FFFF;
    #1;
    chk("hit_din", p_din, 32'h3C01_0000);
    chk("hit_m_strobe", {31'd0, m_strobe}, 32'd0);
    chk("hit_p_ready", {31'd0, p_ready}, 32'd1);
    chk("fill_miss_cnt", miss_cnt, 32'd1);
    advance();
    chk("hit_cnt_inc", hit_cnt, 32'd1);

    // Conflict: 0x104 shares a line with 0x004 and evicts it.
    p_a = 32'h0000_0004; m_ready = 1'b1; m_dout = 32'h1111_1111;
    advance();
    p_a = 32'h0000_0104; m_dout = 32'h2222_2222;
    advance();
    m_ready = 1'b0; m_dout = 32'h0;
    #1;
    chk("conflict_new_din", p_din, 32'h2222_2222);
    chk("conflict_new_strobe", {31'd0, m_strobe}, 32'd0);
    p_a = 32'h0000_0004;
    #1;
    chk("conflict_old_strobe", {31'd0, m_strobe}, 32'd1);
    chk("conflict_old_ready", {31'd0, p_ready}, 32'd0);
    chk_model("conflict");

    // Reset in the same cycle as a memory response must suppress the fill.
    p_a = 32'h0000_0008; m_ready = 1'b1; m_dout = 32'h5555_AAAA; rst = 1'b1;
    advance();
    rst = 1'b0; m_ready = 1'b0;
    #1;
    chk("rst_fill_miss_cnt", miss_cnt, 32'd0);
    chk("rst_fill_hit_cnt", hit_cnt, 32'd0);
    chk("rst_fill_strobe", {31'd0, m_strobe}, 32'd1);
    p_a = 32'h0000_0000;
    #1;
    chk("rst_old_line_strobe", {31'd0, m_strobe}, 32'd1);
    p_a = 32'h0000_0104;
    #1;
    chk("rst_old_line2_strobe", {31'd0, m_strobe}, 32'd1);
    advance();

    // Randomized traffic over a small address pool so hits, conflicts,
    // ignored byte offsets and occasional resets all occur.
    for (int i = 0; i < 600; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'hBFC0_0000 : 32'h0;
      a |= 32'($urandom_range(0, 1)) << 8;
      a |= 32'($urandom_range(0, 7)) << 2;
      a |= 32'($urandom_range(0, 3));
      p_a     = a;
      m_ready = ($urandom_range(0, 2) == 0);
      m_dout  = $urandom;
      rst     = ($urandom_range(0, 63) == 0);
      #1;
      chk_model("rand");
      advance();
    end
    rst = 1'b0;

    // ROM with one-in-six ready pulses over a 16-word straight-line program.
    rst = 1'b1; m_ready = 1'b0;
    advance();
    rst = 1'b0;
    phase = 0;
    for (int w = 0; w < 16; w++) begin
      p_a = 32'(w * 4);
      got = 1'b0;
      for (int c = 0; c < 6 && !got; c++) begin
        m_ready = (phase == 5);
        m_dout  = m_ready ? rom_word(p_a) : 32'hDEAD_0000;
        #1;
        chk_model("rom1");
        if (p_ready) begin
          got = 1'b1;
          chk("rom1_din", p_din, rom_word(p_a));
        end
        advance();
        phase = (phase + 1) % 6;
      end
      chk("rom1_latency", {31'd0, got}, 32'd1);
    end
    m_ready = 1'b0;
    m_dout  = 32'hDEAD_BEEF;
    for (int w = 0; w < 16; w++) begin
      p_a = 32'(w * 4);
      #1;
      chk("rom2_ready", {31'd0, p_ready}, 32'd1);
      chk("rom2_din", p_din, rom_word(p_a));
      advance();
    end
    chk("rom2_miss_cnt", miss_cnt, 32'd16);
    chk("rom2_hit_cnt", hit_cnt, 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
